wb_sram_bridge: RTL and testbench

//   Wishbone B4 classic slave that turns host bus cycles into single-word requests on the memory

---
 rtl/wb_sram_bridge_pkg.sv | 25 ++
 rtl/wb_byte_merge.sv | 16 +
 rtl/wb_sram_bridge.sv | 167 ++++++++++++++++
 tb/tb_wb_sram_bridge.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sram_bridge_pkg.sv
// Shared encodings for the Wishbone-to-SRAM bridge: controller op codes, CSR map, FSM states.
package wb_sram_bridge_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b11;

  localparam logic [31:0] CSR_OPERATION_OFS = 32'h0;
  localparam logic [31:0] CSR_STATUS_OFS    = 32'h4;

  localparam int unsigned STATUS_BUSY_BIT    = 0;
  localparam int unsigned STATUS_TIMEOUT_BIT = 1;

  localparam logic [31:0] OP_MULTIPLICATION = 32'h1;
  localparam logic [31:0] OP_CONVOLUTION    = 32'h2;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRd,
    StWaitRmwRd,
    StWaitWr,
    StResp
  } state_e;

endpackage

// File: rtl/wb_byte_merge.sv
// Per-byte-lane merge: lanes with sel set take new data, the rest keep old data.
module wb_byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (sel_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone B4 classic slave bridging bus cycles onto the memory controller's single-word DMA
// port, with an OPERATION/STATUS CSR window, partial-write RMW and a completion timeout.
module wb_sram_bridge
  import wb_sram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] SRAM_OFFSET    = 32'h0000_1000,
  parameter int unsigned SRAM_AWIDTH    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o,
  output logic [1:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_opdone,
  input  logic [31:0] mem_rdata,
  output logic [31:0] operation
);

  localparam int unsigned CntW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] SramBytes = 32'd4 << SRAM_AWIDTH;

  state_e          state_q;
  logic [CntW-1:0] tmo_cnt_q;
  logic            sticky_q, abort_q, err_pend_q, we_q;
  logic [3:0]      sel_q;
  logic [31:0]     dat_q, rdata_q;

  logic [31:0] off, soff, status, rmw_data, op_merged;
  logic        csr_op_hit, csr_st_hit, sram_hit, req, tmo, aborted;

  assign off        = wb_adr_i - BASE_ADDR;
  assign soff       = off - SRAM_OFFSET;
  assign csr_op_hit = (off & ~32'h3) == CSR_OPERATION_OFS;
  assign csr_st_hit = (off & ~32'h3) == CSR_STATUS_OFS;
  assign sram_hit   = soff < SramBytes;
  // While ack/err is out the master's strobe still belongs to the finished cycle.
  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign tmo        = tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1);
  assign aborted    = abort_q | ~wb_cyc_i;

  always_comb begin
    status                     = '0;
    status[STATUS_BUSY_BIT]    = state_q != StIdle;
    status[STATUS_TIMEOUT_BIT] = sticky_q;
  end

  wb_byte_merge u_rmw_merge (
    .old_i    (mem_rdata),
    .new_i    (dat_q),
    .sel_i    (sel_q),
    .merged_o (rmw_data)
  );

  wb_byte_merge u_csr_merge (
    .old_i    (operation),
    .new_i    (wb_dat_i),
    .sel_i    (wb_sel_i),
    .merged_o (op_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tmo_cnt_q  <= '0;
      sticky_q   <= 1'b0;
      abort_q    <= 1'b0;
      err_pend_q <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
      rdata_q    <= '0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_dat_o   <= '0;
      mem_op     <= MEM_OP_NONE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      operation  <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            we_q       <= wb_we_i;
            sel_q      <= wb_sel_i;
            dat_q      <= wb_dat_i;
            abort_q    <= 1'b0;
            err_pend_q <= 1'b0;
            tmo_cnt_q  <= '0;
            if (csr_op_hit) begin
              if (wb_we_i) operation <= op_merged;
              else         rdata_q   <= operation;
              state_q <= StResp;
            end else if (csr_st_hit) begin
              if (!wb_we_i) rdata_q <= status;
              else if (wb_sel_i[0] && wb_dat_i[STATUS_TIMEOUT_BIT]) sticky_q <= 1'b0;
              state_q <= StResp;
            end else if (sram_hit) begin
              mem_addr  <= soff >> 2;
              mem_wdata <= wb_dat_i;
              if (!wb_we_i) begin
                mem_op  <= MEM_OP_READ;
                state_q <= StWaitRd;
              end else if (wb_sel_i == 4'hf) begin
                mem_op  <= MEM_OP_WRITE;
                state_q <= StWaitWr;
              end else if (wb_sel_i == 4'h0) begin
                state_q <= StResp;
              end else begin
                mem_op  <= MEM_OP_READ;
                state_q <= StWaitRmwRd;
              end
            end else begin
              err_pend_q <= 1'b1;
              state_q    <= StResp;
            end
          end
        end
        StWaitRd, StWaitRmwRd, StWaitWr: begin
          if (!wb_cyc_i) abort_q <= 1'b1;
          tmo_cnt_q <= tmo_cnt_q + CntW'(1);
          if (mem_opdone) begin
            tmo_cnt_q <= '0;
            if (state_q == StWaitRmwRd) begin
              // Write phase of RMW is issued even if the master has gone away.
              mem_wdata <= rmw_data;
              mem_op    <= MEM_OP_WRITE;
              state_q   <= StWaitWr;
            end else begin
              mem_op <= MEM_OP_NONE;
              if (state_q == StWaitRd) rdata_q <= mem_rdata;
              state_q <= aborted ? StIdle : StResp;
            end
          end else if (tmo) begin
            mem_op     <= MEM_OP_NONE;
            sticky_q   <= 1'b1;
            err_pend_q <= 1'b1;
            state_q    <= aborted ? StIdle : StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
          if (err_pend_q) begin
            wb_err_o <= 1'b1;
          end else begin
            wb_ack_o <= 1'b1;
            if (!we_q) wb_dat_o <= rdata_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Randomized self-checking bench for wb_sram_bridge against a word-array reference model.
module tb_wb_sram_bridge;
  import wb_sram_bridge_pkg::*;

  localparam logic [31:0] Base  = 32'h3000_0000;
  localparam logic [31:0] SOfs  = 32'h0000_1000;
  localparam int unsigned Aw    = 10;
  localparam int unsigned Words = 1 << Aw;
  localparam int unsigned Tmo   = 255;

  logic        clk = 1'b0, reset = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o, mem_addr, mem_wdata, operation;
  logic [1:0]  mem_op;
  logic        mem_opdone = 1'b0;
  logic [31:0] mem_rdata = '0;

  wb_sram_bridge #(
    .BASE_ADDR      (Base),
    .SRAM_OFFSET    (SOfs),
    .SRAM_AWIDTH    (Aw),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_sel_i   (wb_sel_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .wb_dat_o   (wb_dat_o),
    .mem_op     (mem_op),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_opdone (mem_opdone),
    .mem_rdata  (mem_rdata),
    .operation  (operation)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory controller model: answers each request after 0..3 idle cycles.
  logic [31:0] sram [Words];
  bit          mem_respond = 1'b1;
  int          mem_delay = -1, mem_reads = 0, mem_writes = 0;
  bit          pending = 1'b0;
  int          delay = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (mem_opdone) begin
        mem_opdone = 1'b0;
        mem_rdata  = $urandom;
      end else if (reset) begin
        pending = 1'b0;
      end else if (pending) begin
        if (delay == 0) begin
          pending    = 1'b0;
          mem_opdone = 1'b1;
          if (mem_op == MEM_OP_WRITE) begin
            sram[mem_addr[Aw-1:0]] = mem_wdata;
            mem_writes++;
          end else begin
            mem_rdata = sram[mem_addr[Aw-1:0]];
            mem_reads++;
          end
        end else begin
          delay--;
        end
      end else if (mem_respond && mem_op != MEM_OP_NONE) begin
        pending = 1'b1;
        delay   = (mem_delay >= 0) ? mem_delay : int'($urandom_range(0, 3));
      end
    end
  end

  int          op_cycles = 0, ack_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [1:0]  last_op = '0;
  logic [31:0] last_addr = '0;

  always @(negedge clk) begin
    if (mem_op != MEM_OP_NONE) begin
      op_cycles++;
      last_op   = mem_op;
      last_addr = mem_addr;
    end
    if (wb_ack_o) ack_cnt++;
    if (wb_err_o) err_cnt++;
    if (wb_ack_o && wb_err_o) both_cnt++;
  end

  // Reference model state.
  logic [31:0] ref_mem [Words];
  logic [31:0] ref_operation = '0;
  logic        ref_sticky = 1'b0;

  function automatic logic [31:0] lane_merge(logic [31:0] old_w, logic [31:0] new_w,
                                             logic [3:0] sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  logic [31:0] rd;
  logic        ga, ge;
  int          ed;

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    ed = 0; ga = 1'b0; ge = 1'b0;
    while (!ga && !ge && ed < 400) begin
      @(posedge clk); ed++;
      @(negedge clk);
      ga = wb_ack_o; ge = wb_err_o; rd = wb_dat_o;
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  function automatic logic [31:0] sram_adr(int unsigned idx);
    return Base + SOfs + 32'(idx * 4);
  endfunction

  function automatic logic [31:0] all_outputs();
    return {29'd0, wb_ack_o, wb_err_o, |mem_op} | wb_dat_o | mem_addr | mem_wdata | operation;
  endfunction

  int ops0, rd0, wr0, ack0;
  logic [31:0] d, a;
  logic [3:0]  s;
  int unsigned idx;

  initial begin
    for (int i = 0; i < int'(Words); i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", all_outputs(), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // CSR write and readback
    bus(1'b1, Base, OP_MULTIPLICATION, 4'hf);
    ref_operation = OP_MULTIPLICATION;
    check_eq("csr_wr_ack", {ge, ga}, 2'b01);
    check_eq("csr_wr_latency", ed, 2);
    check_eq("operation_port", operation, 32'h1);
    bus(1'b0, Base, 32'h0, 4'hf);
    check_eq("csr_rd_data", rd, 32'h1);

    // SRAM write then read
    bus(1'b1, Base + 32'h1008, 32'hDEAD_BEEF, 4'hf);
    ref_mem[2] = 32'hDEAD_BEEF;
    check_eq("sram_wr_ack", {ge, ga}, 2'b01);
    check_eq("sram_wr_op", last_op, MEM_OP_WRITE);
    check_eq("sram_wr_addr", last_addr, 32'd2);
    bus(1'b0, Base + 32'h1008, 32'h0, 4'hf);
    check_eq("sram_rd_data", rd, 32'hDEAD_BEEF);

    // Read-modify-write on a single lane
    bus(1'b1, sram_adr(3), 32'h1122_3344, 4'hf);
    ref_mem[3] = 32'h1122_3344;
    rd0 = mem_reads; wr0 = mem_writes; ack0 = ack_cnt;
    bus(1'b1, sram_adr(3), 32'h0000_00AA, 4'h1);
    ref_mem[3] = 32'h1122_33AA;
    repeat (2) @(negedge clk);
    check_eq("rmw_ack", {ge, ga}, 2'b01);
    check_eq("rmw_reads", mem_reads - rd0, 1);
    check_eq("rmw_writes", mem_writes - wr0, 1);
    check_eq("rmw_ack_count", ack_cnt - ack0, 1);
    check_eq("rmw_mem", sram[3], 32'h1122_33AA);

    // Completion timeout and sticky clear
    mem_respond = 1'b0;
    bus(1'b0, sram_adr(7), 32'h0, 4'hf);
    ref_sticky = 1'b1;
    check_eq("tmo_err", {ge, ga}, 2'b10);
    check_eq("tmo_latency_ok", (ed >= int'(Tmo) && ed <= int'(Tmo) + 5) ? 1 : 0, 1);
    check_eq("tmo_mem_op", mem_op, MEM_OP_NONE);
    mem_respond = 1'b1;
    bus(1'b0, Base + 32'h4, 32'h0, 4'hf);
    check_eq("status_sticky", rd, {30'd0, ref_sticky, 1'b0});
    bus(1'b1, Base + 32'h4, 32'h2, 4'h1);
    ref_sticky = 1'b0;
    bus(1'b0, Base + 32'h4, 32'h0, 4'hf);
    check_eq("status_cleared", rd, {30'd0, ref_sticky, 1'b0});

    // Decode misses
    ops0 = op_cycles;
    bus(1'b0, Base + 32'h8, 32'h0, 4'hf);
    check_eq("miss_csr_err", {ge, ga}, 2'b10);
    bus(1'b1, Base + SOfs + (32'd4 << Aw), 32'h55, 4'hf);
    check_eq("miss_top_err", {ge, ga}, 2'b10);
    check_eq("miss_no_memop", op_cycles - ops0, 0);

    // Drop cyc while waiting for a read
    mem_delay = 3;
    rd0 = mem_reads; ack0 = ack_cnt + err_cnt;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hf;
    wb_adr_i = sram_adr(5);
    for (int i = 0; i < 10 && mem_op != MEM_OP_READ; i++) @(negedge clk);
    check_eq("abort_op_started", mem_op, MEM_OP_READ);
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (12) @(negedge clk);
    mem_delay = -1;
    check_eq("abort_no_resp", ack_cnt + err_cnt - ack0, 0);
    check_eq("abort_read_done", mem_reads - rd0, 1);
    check_eq("abort_idle_op", mem_op, MEM_OP_NONE);
    bus(1'b0, sram_adr(5), 32'h0, 4'hf);
    check_eq("after_abort_rd", rd, ref_mem[5]);

    // Reset while a write is outstanding
    mem_respond = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hf;
    wb_adr_i = sram_adr(9); wb_dat_i = 32'hCAFE_F00D;
    for (int i = 0; i < 10 && mem_op != MEM_OP_WRITE; i++) @(negedge clk);
    check_eq("rst_op_started", mem_op, MEM_OP_WRITE);
    @(posedge clk); #1;
    reset = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ref_operation = '0; ref_sticky = 1'b0;
    @(negedge clk);
    check_eq("rst_outputs", all_outputs(), 32'd0);
    mem_respond = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      idx = $urandom_range(0, Words - 1);
      d   = $urandom;
      s   = 4'($urandom);
      ops0 = op_cycles;
      case ($urandom_range(0, 6))
        0: begin
          bus(1'b1, Base, d, s);
          ref_operation = lane_merge(ref_operation, d, s);
          check_eq("rnd_csr_wr", {ge, ga}, 2'b01);
          check_eq("rnd_csr_lat", ed, 2);
          check_eq("rnd_op_port", operation, ref_operation);
        end
        1: begin
          bus(1'b0, Base, 32'h0, 4'hf);
          check_eq("rnd_csr_rd", rd, ref_operation);
        end
        2: begin
          bus(1'b1, sram_adr(idx), d, 4'hf);
          ref_mem[idx] = d;
          check_eq("rnd_wr_full", {ge, ga}, 2'b01);
        end
        3: begin
          bus(1'b1, sram_adr(idx), d, s);
          ref_mem[idx] = lane_merge(ref_mem[idx], d, s);
          check_eq("rnd_wr_part", {ge, ga}, 2'b01);
          if (s == 4'h0) check_eq("rnd_sel0_no_memop", op_cycles - ops0, 0);
        end
        4, 5: begin
          bus(1'b0, sram_adr(idx), 32'h0, 4'hf);
          check_eq("rnd_rd_ack", {ge, ga}, 2'b01);
          check_eq("rnd_rd_data", rd, ref_mem[idx]);
        end
        default: begin
          case ($urandom_range(0, 2))
            0:       a = Base + 32'h8 + 32'(4 * $urandom_range(0, 1021));
            1:       a = Base + 32'h2000 + 32'(4 * $urandom_range(0, 4095));
            default: a = Base - 32'(4 * $urandom_range(1, 4095));
          endcase
          bus(1'($urandom), a, d, 4'hf);
          check_eq("rnd_miss_err", {ge, ga}, 2'b10);
          check_eq("rnd_miss_no_memop", op_cycles - ops0, 0);
        end
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(negedge clk);
    check_eq("ack_err_exclusive", both_cnt, 0);
    for (int i = 0; i < int'(Words); i++) check_eq("final_mem", sram[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
